// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS instruction fetch path.
// Provides the NOP encoding, byte-to-word index helper and parameter checks.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Byte address to word index; callers widen to 64 bits first.
    function automatic logic [63:0] word_idx(input logic [63:0] addr);
        return addr >> 2;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W instruction storage: one registered read port, one write port.
// Ports: i_rd_en/i_rd_idx -> o_rd_data (next edge), i_wr_en/i_wr_idx/i_wr_data.
module imem_array #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    AW        = $clog2(DEPTH),
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Read and write share the edge; the read samples the old word.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_pipelined_fetch.sv
// Pipelined IF-stage instruction memory with stall/flush, load port and faults.
// Ports: fetch_req/fetch_pc in, instr/instr_valid/fault_* out, wr_* load port.
module imem_pipelined_fetch
    import mips_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1024,
    parameter int    ADDR_W    = 32,
    parameter int    READ_LAT  = 1,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              stall,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fault_misalign,
    output logic              fault_range
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INSTR);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("imem_pipelined_fetch: DEPTH must be a power of two >= 2");
    end
    if (!lat_ok(READ_LAT)) begin : g_bad_lat
        $error("imem_pipelined_fetch: READ_LAT must be 1 or 2");
    end

    logic [63:0]       w_pc_idx;
    logic [63:0]       w_wr_idx;
    logic              w_mis;
    logic              w_rng;
    logic              w_acc;
    logic              w_we;
    logic [DATA_W-1:0] w_rd_data;

    // Full-width index compare: out-of-range PCs never alias into the array.
    assign w_pc_idx = word_idx(64'(fetch_pc));
    assign w_wr_idx = word_idx(64'(wr_addr));
    assign w_mis    = |fetch_pc[1:0];
    assign w_rng    = !w_mis && (w_pc_idx >= 64'(DEPTH));
    assign w_acc    = fetch_req && !stall && !flush;
    assign w_we     = wr_en && rst_n && (wr_addr[1:0] == 2'b00)
                      && (w_wr_idx < 64'(DEPTH));

    imem_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk       (clk),
        .i_rd_en   (w_acc),
        .i_rd_idx  (w_pc_idx[AW-1:0]),
        .o_rd_data (w_rd_data),
        .i_wr_en   (w_we),
        .i_wr_idx  (w_wr_idx[AW-1:0]),
        .i_wr_data (wr_data)
    );

    logic r_s1_v;
    logic r_s1_mis;
    logic r_s1_rng;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_s1_v   <= 1'b0;
            r_s1_mis <= 1'b0;
            r_s1_rng <= 1'b0;
        end else if (!stall) begin
            r_s1_v   <= fetch_req;
            r_s1_mis <= fetch_req && w_mis;
            r_s1_rng <= fetch_req && w_rng;
        end
    end

    // The array's read register is stage 1 data; faulted fetches deliver NOP.
    logic [DATA_W-1:0] w_s1_instr;
    logic              w_s1_mis;
    logic              w_s1_rng;

    assign w_s1_instr = (r_s1_v && !r_s1_mis && !r_s1_rng) ? w_rd_data : NOP;
    assign w_s1_mis   = r_s1_v && r_s1_mis;
    assign w_s1_rng   = r_s1_v && r_s1_rng;

    if (READ_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] r_s2_instr;
        logic              r_s2_v;
        logic              r_s2_mis;
        logic              r_s2_rng;

        always_ff @(posedge clk) begin
            if (!rst_n || flush) begin
                r_s2_instr <= NOP;
                r_s2_v     <= 1'b0;
                r_s2_mis   <= 1'b0;
                r_s2_rng   <= 1'b0;
            end else if (!stall) begin
                r_s2_instr <= w_s1_instr;
                r_s2_v     <= r_s1_v;
                r_s2_mis   <= w_s1_mis;
                r_s2_rng   <= w_s1_rng;
            end
        end

        assign instr          = r_s2_instr;
        assign instr_valid    = r_s2_v;
        assign fault_misalign = r_s2_mis;
        assign fault_range    = r_s2_rng;
    end else begin : g_lat1
        assign instr          = w_s1_instr;
        assign instr_valid    = r_s1_v;
        assign fault_misalign = w_s1_mis;
        assign fault_range    = w_s1_rng;
    end

endmodule

// File: tb/tb_imem_pipelined_fetch.sv
// Scoreboard bench: drives READ_LAT=1 and READ_LAT=2 instances in lockstep.
// A transaction-level model predicts each delivered fetch per instance.
module tb_imem_pipelined_fetch;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        stall;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    logic [31:0] o_instr [2];
    logic        o_v     [2];
    logic        o_mis   [2];
    logic        o_rng   [2];

    always #5 clk = ~clk;

    imem_pipelined_fetch #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(32), .READ_LAT(1), .INIT_FILE("")
    ) u_lat1 (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .stall(stall), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .instr(o_instr[0]), .instr_valid(o_v[0]),
        .fault_misalign(o_mis[0]), .fault_range(o_rng[0])
    );

    imem_pipelined_fetch #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(32), .READ_LAT(2), .INIT_FILE("")
    ) u_lat2 (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .stall(stall), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .instr(o_instr[1]), .instr_valid(o_v[1]),
        .fault_misalign(o_mis[1]), .fault_range(o_rng[1])
    );

    typedef struct {
        logic [31:0]     d;
        bit              mis;
        bit              rng;
        longint unsigned due;
    } exp_t;

    exp_t            q0 [$];
    exp_t            q1 [$];
    logic [31:0]     mem_m [DEPTH];
    longint unsigned adv = 0;
    bit              mon_en = 1'b0;
    int              ntests = 0;
    int              nfail = 0;

    // Reference: a fetch accepted on an advancing edge is delivered after
    // READ_LAT advancing edges in total; stalls freeze, flush/reset discard.
    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            mon_en = 1'b1;
        end else begin
            e.mis = (fetch_pc[1:0] != 2'b00);
            e.rng = !e.mis && ((fetch_pc >> 2) >= DEPTH);
            e.d   = (e.mis || e.rng) ? 32'h0 : mem_m[int'(fetch_pc >> 2)];
            if (flush) begin
                q0.delete();
                q1.delete();
            end else if (!stall) begin
                adv++;
                if (fetch_req) begin
                    e.due = adv;
                    q0.push_back(e);
                    e.due = adv + 1;
                    q1.push_back(e);
                end
            end
            if (wr_en && wr_addr[1:0] == 2'b00 && (wr_addr >> 2) < DEPTH)
                mem_m[int'(wr_addr >> 2)] = wr_data;
        end
    end

    task automatic chk(input int k, input bit has, input exp_t e);
        ntests++;
        if (has) begin
            if (o_v[k] !== 1'b1 || o_instr[k] !== e.d ||
                o_mis[k] !== e.mis || o_rng[k] !== e.rng) begin
                nfail++;
                $display("FAIL fetch_lat%0d t=%0t: got v=%b instr=%h mis=%b rng=%b, want v=1 instr=%h mis=%b rng=%b",
                         k + 1, $time, o_v[k], o_instr[k], o_mis[k], o_rng[k],
                         e.d, e.mis, e.rng);
            end
        end else if (o_v[k] !== 1'b0 || o_instr[k] !== 32'h0) begin
            nfail++;
            $display("FAIL idle_lat%0d t=%0t: got v=%b instr=%h, want v=0 instr=00000000",
                     k + 1, $time, o_v[k], o_instr[k]);
        end
    endtask

    always @(negedge clk) begin
        exp_t h0;
        exp_t h1;
        if (mon_en) begin
            while (q0.size() != 0 && q0[0].due < adv) void'(q0.pop_front());
            while (q1.size() != 0 && q1[0].due < adv) void'(q1.pop_front());
            h0 = '{d: 32'h0, mis: 1'b0, rng: 1'b0, due: 0};
            h1 = h0;
            if (q0.size() != 0) h0 = q0[0];
            if (q1.size() != 0) h1 = q1[0];
            chk(0, q0.size() != 0 && h0.due == adv, h0);
            chk(1, q1.size() != 0 && h1.due == adv, h1);
        end
    end

    task automatic step(input bit rq, input logic [31:0] pc, input bit st,
                        input bit fl, input bit we, input logic [31:0] wa,
                        input logic [31:0] wd);
        fetch_req = rq;
        fetch_pc  = pc;
        stall     = st;
        flush     = fl;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_pc();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 6) return 32'($urandom_range(0, DEPTH - 1)) << 2;
        if (sel == 7) return (32'($urandom_range(0, 63)) << 2)
                             | 32'($urandom_range(1, 3));
        if (sel == 8) return 32'(DEPTH * 4) + (32'($urandom_range(0, 500)) << 2);
        return ($urandom() & 32'hFFFF_FFFC) | 32'h8000_0000;
    endfunction

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h0109_5020;
        prog[1] = 32'hAC0A_0000;
        prog[2] = 32'h0149_5822;
        prog[3] = 32'h1168_FFFC;

        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            step(0, 0, 0, 0, 1, 32'(i * 4),
                 (i < 4) ? prog[i] : $urandom());
        idle(1);

        for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 0, 0, 0, 0, 0);
        idle(3);

        step(1, 32'h4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 32'h8, 1, 0, 0, 0, 0);
        idle(3);

        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(1, 32'h4, 0, 0, 0, 0, 0);
        step(1, 32'h8, 1, 1, 0, 0, 0);
        idle(3);

        step(1, 32'h6, 0, 0, 0, 0, 0);
        step(1, 32'(DEPTH * 4), 0, 0, 0, 0, 0);
        idle(3);

        step(1, 32'h8, 0, 0, 1, 32'h8, 32'hDEAD_BEEF);
        step(1, 32'h8, 0, 0, 0, 0, 0);
        step(1, 32'h8, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step(1, 32'h8, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1, 32'h8, 0, 0, 0, 0, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 3) != 0, rand_pc(),
                 $urandom_range(0, 6) == 0, $urandom_range(0, 13) == 0,
                 $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 3) == 0) ? rand_pc()
                     : 32'($urandom_range(0, DEPTH - 1)) << 2,
                 $urandom());
        end
        rst_n = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
